// File: rtl/e_q_clk_gen.sv
// 6809-style quadrature E/Q bus clock generator with MRDY stretching and a timeout.
// Optional `ECLK_CYCLE_COUNT_EN adds a free-running 16-bit count of E falling edges.
module e_q_clk_gen #(
  parameter int QUARTER_CYCLES = 25,
  parameter int CNT_W          = 8,
  parameter int STRETCH_MAX    = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_mrdy,
  output logic        o_e,
  output logic        o_q,
  output logic        o_e_rise,
  output logic        o_e_fall,
  output logic        o_stretching,
`ifdef ECLK_CYCLE_COUNT_EN
  output logic [15:0] o_cycle_count,
`endif
  output logic        o_stretch_timeout
);

  localparam int SW = $clog2(STRETCH_MAX + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(QUARTER_CYCLES - 1);
  localparam logic [SW-1:0]    SMAX   = SW'(STRETCH_MAX);

  typedef enum logic [2:0] {S_IDLE, S_Q0, S_Q1, S_Q2, S_Q3, S_STRETCH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    str_q, str_d;
  logic             e_q, e_d, q_q, q_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic             stretching_q, stretching_d, timeout_q, timeout_d;
  logic             qend;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    str_d     = str_q;
    timeout_d = 1'b0;
    qend      = (cnt_q == '0);
    if (state_q == S_IDLE) begin
      if (i_enable) begin
        state_d = S_Q0;
        cnt_d   = RELOAD;
      end
    end else if (!qend) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = RELOAD;
      case (state_q)
        S_Q0: begin
          if (i_enable) state_d = S_Q1;
          else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_Q1: state_d = S_Q2;
        S_Q2: state_d = S_Q3;
        S_Q3: begin
          if (i_mrdy) state_d = S_Q0;
          else begin
            state_d = S_STRETCH;
            str_d   = SW'(1);
          end
        end
        S_STRETCH: begin
          // Ready wins over the timeout when both land on the same quarter end.
          if (i_mrdy) begin
            state_d = S_Q0;
            str_d   = '0;
          end else if (str_q == SMAX) begin
            state_d   = S_Q0;
            str_d     = '0;
            timeout_d = 1'b1;
          end else begin
            str_d = str_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    e_d = 1'b0;
    q_d = 1'b0;
    case (state_d)
      S_Q1:      q_d = 1'b1;
      S_Q2:      begin e_d = 1'b1; q_d = 1'b1; end
      S_Q3:      e_d = 1'b1;
      S_STRETCH: e_d = 1'b1;
      default:   ;
    endcase
    rise_d       = e_d & ~e_q;
    fall_d       = ~e_d & e_q;
    stretching_d = (state_d == S_STRETCH);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      str_q        <= '0;
      e_q          <= 1'b0;
      q_q          <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      stretching_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      str_q        <= str_d;
      e_q          <= e_d;
      q_q          <= q_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      stretching_q <= stretching_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef ECLK_CYCLE_COUNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q + {15'd0, fall_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign o_cycle_count = cyc_q;
`endif

  assign o_e               = e_q;
  assign o_q               = q_q;
  assign o_e_rise          = rise_q;
  assign o_e_fall          = fall_q;
  assign o_stretching      = stretching_q;
  assign o_stretch_timeout = timeout_q;

endmodule
